// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, mux select values,
// default widths and a counter-width helper.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_DM = 1'b1;

  localparam int DEF_DW          = 32;
  localparam int DEF_AW          = 32;
  localparam int DEF_MAX_DM_RUN  = 4;
  localparam int DEF_TIMEOUT_CYC = 255;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between fetch and data requests, with a
// run limit that lets a waiting fetch through after MAX_DM_RUN data grants.
module arb_pick
  import arb_pkg::*;
#(
  parameter int MAX_DM_RUN = DEF_MAX_DM_RUN,
  parameter int CNT_W      = cnt_width(MAX_DM_RUN)
) (
  input  logic             if_req,
  input  logic             dm_req,
  input  logic [CNT_W-1:0] run_cnt,
  output logic             grant,
  output logic             sel
);

  always_comb begin
    grant = if_req | dm_req;
    sel   = SEL_IF;
    if (dm_req && !(if_req && (run_cnt == CNT_W'(MAX_DM_RUN))))
      sel = SEL_DM;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// Optional watchdog on stalled memory transactions: define ARB_TIMEOUT_EN.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int AW          = DEF_AW,
  parameter int MAX_DM_RUN  = DEF_MAX_DM_RUN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          sel,
`ifdef ARB_TIMEOUT_EN
  output logic          err,
`endif
  output logic          busy
);

  localparam int CNT_W = cnt_width(MAX_DM_RUN);

  if (MAX_DM_RUN < 1 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("mem_port_arbiter: MAX_DM_RUN and TIMEOUT_CYC must be at least 1");
  end

  state_t           state_q, state_d;
  logic             load;
  logic             pick_grant, pick_sel;
  logic             sel_q, we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q, if_rdata_q, dm_rdata_q;
  logic [CNT_W-1:0] run_cnt_q;

  arb_pick #(
    .MAX_DM_RUN (MAX_DM_RUN),
    .CNT_W      (CNT_W)
  ) u_pick (
    .if_req  (if_req),
    .dm_req  (dm_req),
    .run_cnt (run_cnt_q),
    .grant   (pick_grant),
    .sel     (pick_sel)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = (cnt_width(TIMEOUT_CYC) > 8) ? cnt_width(TIMEOUT_CYC) : 8;
  logic [WD_W-1:0] wd_q;
  logic            timeout;
  logic            err_q;
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    timeout = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_grant) begin
          state_d = ST_BUSY;
          load    = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          state_d = ST_DONE;
        end
`ifdef ARB_TIMEOUT_EN
        // Last permitted BUSY cycle without a response: give up and report.
        else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          state_d = ST_DONE;
          timeout = 1'b1;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= SEL_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      run_cnt_q  <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (load) begin
        sel_q   <= pick_sel;
        addr_q  <= (pick_sel == SEL_DM) ? dm_addr : if_addr;
        we_q    <= (pick_sel == SEL_DM) & dm_we;
        wdata_q <= (pick_sel == SEL_DM) ? dm_wdata : '0;
        // Only consecutive data grants that kept a fetch waiting count toward the limit.
        if (pick_sel == SEL_IF)
          run_cnt_q <= '0;
        else if (if_req && (run_cnt_q != CNT_W'(MAX_DM_RUN)))
          run_cnt_q <= run_cnt_q + 1'b1;
      end else if (state_q == ST_DONE) begin
        sel_q <= SEL_IF;
      end

      if ((state_q == ST_BUSY) && mem_ready) begin
        if (sel_q == SEL_DM)
          dm_rdata_q <= mem_rdata;
        else
          if_rdata_q <= mem_rdata;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (load)
        wd_q <= '0;
      else if (state_q == ST_BUSY)
        wd_q <= wd_q + 1'b1;
      err_q <= timeout;
    end
  end

  assign err = err_q;
`endif

  assign mem_req   = (state_q == ST_BUSY);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_done   = (state_q == ST_DONE) && (sel_q == SEL_IF);
  assign dm_done   = (state_q == ST_DONE) && (sel_q == SEL_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign sel       = sel_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: expected grants and completions are
// queued as stimulus is issued and compared when the DUT presents them.
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          sel;
  logic          busy;
`ifdef ARB_TIMEOUT_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DW          (DW),
    .AW          (AW),
    .MAX_DM_RUN  (4),
`ifdef ARB_TIMEOUT_EN
    .TIMEOUT_CYC (8)
`else
    .TIMEOUT_CYC (255)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .sel       (sel),
`ifdef ARB_TIMEOUT_EN
    .err       (err),
`endif
    .busy      (busy)
  );

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    logic        sel;
    logic        chk;
    logic [31:0] rdata;
    logic        err;
  } done_t;

  grant_t exp_g[$];
  done_t  exp_d[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_start = 0;
  int last_if_done_cyc = 0;
  int last_dm_done_cyc = 0;
  int mem_lat = 0;
  bit mem_stuck = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'h2048_0005;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_g(input logic s, input logic [31:0] a, input logic w, input logic [31:0] wd);
    grant_t g;
    g.sel = s; g.addr = a; g.we = w; g.wdata = wd;
    exp_g.push_back(g);
  endtask

  task automatic push_d(input logic s, input logic c, input logic [31:0] rd, input logic e);
    done_t d;
    d.sel = s; d.chk = c; d.rdata = rd; d.err = e;
    exp_d.push_back(d);
  endtask

  // Memory model: answers after mem_lat wait cycles, garbage data otherwise.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !mem_stuck) begin
        wcnt++;
        if (wcnt > mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = memfn(mem_addr);
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        if (!mem_req) wcnt = 0;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: grants and completions against the scoreboard.
  initial begin
    grant_t cur;
    done_t  d;
    logic   prev_req;
    prev_req = 1'b0;
    cur = '{sel: 1'b0, addr: 32'h0, we: 1'b0, wdata: 32'h0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          busy_start = cyc;
          if (exp_g.size() == 0) begin
            check_eq("grant_unexpected", 1, 0);
          end else begin
            cur = exp_g.pop_front();
            check_eq("grant_sel", sel, cur.sel);
            check_eq("grant_addr", mem_addr, cur.addr);
            check_eq("grant_we", mem_we, cur.we);
            if (cur.we) check_eq("grant_wdata", mem_wdata, cur.wdata);
          end
        end
        if (mem_req) check_eq("addr_hold", mem_addr, cur.addr);
        if (if_done && dm_done) check_eq("done_both", 1, 0);
        if (if_done || dm_done) begin
          if (exp_d.size() == 0) begin
            check_eq("done_unexpected", 1, 0);
          end else begin
            d = exp_d.pop_front();
            check_eq("done_port", dm_done, d.sel);
            if (d.chk) check_eq("done_rdata", d.sel ? dm_rdata : if_rdata, d.rdata);
`ifdef ARB_TIMEOUT_EN
            check_eq("done_err", err, d.err);
`endif
          end
          if (dm_done) last_dm_done_cyc = cyc;
          else         last_if_done_cyc = cyc;
        end
        prev_req = mem_req;
      end
    end
  end

  task automatic if_txn(input logic [31:0] a);
    if_req  = 1'b1;
    if_addr = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if_done) begin
        if_req = 1'b0;
        return;
      end
    end
    check_eq("if_wait_timeout", 0, 1);
    if_req = 1'b0;
  endtask

  task automatic dm_txn(input logic w, input logic [31:0] a, input logic [31:0] wd);
    dm_req   = 1'b1;
    dm_we    = w;
    dm_addr  = a;
    dm_wdata = wd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dm_done) begin
        dm_req = 1'b0;
        dm_we  = 1'b0;
        return;
      end
    end
    check_eq("dm_wait_timeout", 0, 1);
    dm_req = 1'b0;
    dm_we  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", {if_done, dm_done}, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_rdata", {if_rdata, dm_rdata}, 0);
    rst = 1'b0;

    // Single fetch with two memory wait cycles.
    mem_lat = 2;
    push_g(1'b0, 32'h0040_0000, 1'b0, 32'h0);
    push_d(1'b0, 1'b1, 32'h2008_0005, 1'b0);
    @(negedge clk);
    if_txn(32'h0040_0000);
    repeat (2) @(negedge clk);
    check_eq("if_rdata_hold", if_rdata, 32'h2008_0005);
    check_eq("idle_busy", busy, 0);

    // Simultaneous requests: store wins first, fetch follows.
    mem_lat = 0;
    push_g(1'b1, 32'h1001_0004, 1'b1, 32'hDEAD_BEEF);
    push_g(1'b0, 32'h0040_0010, 1'b0, 32'h0);
    push_d(1'b1, 1'b0, 32'h0, 1'b0);
    push_d(1'b0, 1'b1, memfn(32'h0040_0010), 1'b0);
    @(negedge clk);
    fork
      if_txn(32'h0040_0010);
      dm_txn(1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
    join
    check_eq("coll_order", last_if_done_cyc > last_dm_done_cyc, 1);
    check_eq("coll_gap", (last_if_done_cyc - last_dm_done_cyc) >= 3, 1);

    // Starvation limit: four data grants, then the waiting fetch, then data again.
    for (int i = 0; i < 4; i++) push_g(1'b1, 32'h1000_0100 + 32'(4 * i), 1'b0, 32'h0);
    push_g(1'b0, 32'h0040_0020, 1'b0, 32'h0);
    push_g(1'b1, 32'h1000_0110, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) push_d(1'b1, 1'b1, memfn(32'h1000_0100 + 32'(4 * i)), 1'b0);
    push_d(1'b0, 1'b1, memfn(32'h0040_0020), 1'b0);
    push_d(1'b1, 1'b1, memfn(32'h1000_0110), 1'b0);
    @(negedge clk);
    fork
      if_txn(32'h0040_0020);
      begin
        for (int i = 0; i < 5; i++) dm_txn(1'b0, 32'h1000_0100 + 32'(4 * i), 32'h0);
      end
    join

    // Run count was cleared by the fetch grant, so data wins the next collision.
    push_g(1'b1, 32'h1000_0200, 1'b1, 32'h1234_5678);
    push_g(1'b0, 32'h0040_0030, 1'b0, 32'h0);
    push_d(1'b1, 1'b0, 32'h0, 1'b0);
    push_d(1'b0, 1'b1, memfn(32'h0040_0030), 1'b0);
    @(negedge clk);
    fork
      if_txn(32'h0040_0030);
      dm_txn(1'b1, 32'h1000_0200, 32'h1234_5678);
    join

    // Reset during the third BUSY cycle of a stalled store.
    mem_stuck = 1'b1;
    push_g(1'b1, 32'h1000_0300, 1'b1, 32'hCAFE_F00D);
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1000_0300; dm_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_eq("busy_before_rst", {busy, sel, mem_req}, 3'b111);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async", {mem_req, sel, busy}, 0);
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    check_eq("rst_no_done", {if_done, dm_done}, 0);
    rst = 1'b0;
    mem_stuck = 1'b0;
    repeat (3) @(negedge clk);
    mem_lat = 1;
    push_g(1'b0, 32'h0040_0100, 1'b0, 32'h0);
    push_d(1'b0, 1'b1, memfn(32'h0040_0100), 1'b0);
    if_txn(32'h0040_0100);

    // Fetch address changes while BUSY; the latched address must be used.
    mem_lat = 3;
    push_g(1'b0, 32'h0040_0200, 1'b0, 32'h0);
    push_d(1'b0, 1'b1, memfn(32'h0040_0200), 1'b0);
    @(negedge clk);
    fork
      if_txn(32'h0040_0200);
      begin
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
        if_addr = 32'h0BAD_0000;
      end
    join

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: watchdog ends the transaction with err.
    mem_stuck = 1'b1;
    push_g(1'b0, 32'h0040_0300, 1'b0, 32'h0);
    push_d(1'b0, 1'b1, memfn(32'h0040_0200), 1'b1);
    @(negedge clk);
    if_txn(32'h0040_0300);
    check_eq("to_latency", last_if_done_cyc - busy_start, 8);
    mem_stuck = 1'b0;
    @(negedge clk);
    check_eq("to_idle", {busy, err}, 0);
`endif

    repeat (2) @(negedge clk);
    check_eq("grants_left", exp_g.size(), 0);
    check_eq("dones_left", exp_d.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
